row_max_argmax_stream: RTL and testbench
========================================

Name: row_max_argmax_stream

Overview:
- Streaming max/argmax reducer for the attention softmax path.
- Accepts a score row as LANES-wide beats over a valid/ready handshake. Reduces each beat with a balanced comparator tree and folds the beat result into a running max across beats.
- On the last beat, emits the row maximum, its flat element index and an overflow flag through a registered output stage with backpressure.
- Supersedes the fixed 16-input combinational max selector: adds arbitrary row length, argmax, signed/unsigned mode and handshaking.

Parameters:
- D_W, 16, element width in bits.
- LANES, 16, elements per beat; power of two, >=2.
- MAX_BEATS, 64, maximum beats per row counted toward the result; power of two, >=1.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.
- IDX_W, $clog2(LANES*MAX_BEATS), derived localparam; width of O_IDX.

Ports:
- I_CLK  input  1  clock; all logic on rising edge.
- I_RST  input  1  synchronous active-high reset.
- I_VALID  input  1  input beat valid.
- O_READY  output  1  block can accept a beat.
- I_DATA  input  D_W x [0:LANES-1]  beat elements; lane 0 = lowest index.
- I_LAST  input  1  qualifies the final beat of a row.
- O_VALID  output  1  result valid.
- I_READY  input  1  downstream accepts the result.
- O_MAX  output  D_W  row maximum.
- O_IDX  output  IDX_W  flat index of the maximum: beat_number*LANES + lane.
- O_OVF  output  1  row exceeded MAX_BEATS beats.

Behaviour:
- Handshake terms:
  - Beat accepted when I_VALID && O_READY.
  - Result consumed when O_VALID && I_READY.
  - O_READY = !O_VALID || I_READY (combinational). Input stalls only while an unconsumed result is held.
- Compare rule:
  - "a beats b" iff a > b, evaluated signed if SIGNED=1, else unsigned.
  - Ties resolve to the lower flat index, both within the tree (left operand kept on equality) and across beats (accumulator kept on equality).
- Beat tree:
  - log2(LANES) combinational levels produce beat_max and beat_lane (lane index of the winner).
  - Not registered; the path depth is one clock cycle.
- State machine:
  - S_FIRST: no partial row. An accepted beat loads acc_max = beat_max and acc_idx = beat_lane, and sets beat_cnt = 1. With I_LAST it finalizes; otherwise the FSM moves to S_ACC.
  - S_ACC: each accepted beat with beat_cnt < MAX_BEATS is compared; if beat_max beats acc_max, then acc_max = beat_max and acc_idx = beat_cnt*LANES + beat_lane. beat_cnt increments, saturating at MAX_BEATS.
  - Accepted beats with beat_cnt == MAX_BEATS do not update the accumulator and set the sticky ovf flag.
  - An accepted beat with I_LAST finalizes and returns the FSM to S_FIRST.
- Finalize:
  - On the accepting edge, O_MAX, O_IDX and O_OVF load the final accumulator values, including the last beat's contribution (comparison applied in the same cycle), and O_VALID is set.
  - Latency: last beat accepted at edge T -> O_VALID high after edge T; the result is visible in the cycle following T.
  - Single-beat rows are supported.
- Output hold:
  - O_MAX, O_IDX and O_OVF are stable while O_VALID && !I_READY.
  - O_VALID clears on consume unless a new finalize occurs on the same edge. A same-edge finalize overwrites the outputs and O_VALID stays 1, giving back-to-back rows at full throughput.
  - The next row's beats may be accepted while a result is pending, whenever O_READY = 1.
- Reset:
  - O_VALID=0, O_MAX=0, O_IDX=0, O_OVF=0, state S_FIRST, beat_cnt=0, acc_max=0, acc_idx=0, ovf=0.
  - Reset mid-row discards the partial row; the next beat is treated as the first of a new row.
- Inputs are ignored when I_VALID=0. I_DATA and I_LAST are don't-care unless the beat is accepted.

Test Plan:
- SIGNED=1, LANES=16, one beat, I_DATA = {-5, 3, 7, -1, 0...0}, I_LAST=1 -> next cycle O_VALID=1, O_MAX=7, O_IDX=2, O_OVF=0.
- Three-beat row with all elements -100 except beat1 lane5 = 0x7FFF and beat2 lane0 = 0x7FFF -> O_MAX=0x7FFF, O_IDX=21 (tie keeps the earlier element), O_VALID exactly one cycle after the beat2 accept.
- SIGNED=0, single beat with 0x8000 in lane 9 and 0x7FFF elsewhere -> O_MAX=0x8000, O_IDX=9. Same stimulus with SIGNED=1 -> O_MAX=0x7FFF, O_IDX=0.
- Backpressure: hold I_READY=0 for 5 cycles after a result is presented -> outputs stable, O_READY=0, I_VALID beats not accepted. Raise I_READY while the next row's single-beat last is valid -> new result on the following cycle, O_VALID continuously 1.
- MAX_BEATS=4, 6-beat row with value 50 in beat5 lane0 and a maximum of 10 elsewhere at beat0 lane3 -> O_MAX=10, O_IDX=3, O_OVF=1. The next row reports O_OVF=0.
- Assert I_RST after beat1 of a row with a large value 900, then send a fresh one-beat row with max 4 at lane 6 -> O_MAX=4, O_IDX=6. All outputs read 0 on the cycle after reset.

Source files
------------

// File: rtl/row_max_argmax_stream.sv
// Streaming row max/argmax reducer: a per-beat comparator tree folded into a running
// accumulator, with a registered, backpressured result stage.
module row_max_argmax_stream #(
  parameter int unsigned  D_W       = 16,
  parameter int unsigned  LANES     = 16,
  parameter int unsigned  MAX_BEATS = 64,
  parameter bit           SIGNED    = 1'b1,
  localparam int unsigned IDX_W     = $clog2(LANES * MAX_BEATS)
) (
  input  logic                      I_CLK,
  input  logic                      I_RST,
  input  logic                      I_VALID,
  output logic                      O_READY,
  input  logic [0:LANES-1][D_W-1:0] I_DATA,
  input  logic                      I_LAST,
  output logic                      O_VALID,
  input  logic                      I_READY,
  output logic [D_W-1:0]            O_MAX,
  output logic [IDX_W-1:0]          O_IDX,
  output logic                      O_OVF
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);

  typedef enum logic [0:0] {StFirst, StAcc} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [D_W-1:0]     acc_max_q, acc_max_d;
  logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [D_W-1:0]     out_max_q, out_max_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_ovf_q, out_ovf_d;

  logic [D_W-1:0]     beat_max;
  logic [LANE_W-1:0]  beat_lane;
  logic               accept;
  logic               consume;

  // Strict compare; equality keeps the incumbent so ties go to the lower index.
  function automatic logic beats(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
    if (SIGNED) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Balanced tree reduced in place: node n of each level is built from nodes 2n, 2n+1
  // of the previous level, so the left (lower-lane) operand is always kept on a tie.
  always_comb begin : p_tree
    logic [D_W-1:0]    m [LANES];
    logic [LANE_W-1:0] x [LANES];
    for (int unsigned l = 0; l < LANES; l++) begin
      m[l] = I_DATA[l];
      x[l] = LANE_W'(l);
    end
    for (int unsigned w = LANES / 2; w >= 1; w = w / 2) begin
      for (int unsigned n = 0; n < w; n++) begin
        if (beats(m[2*n+1], m[2*n])) begin
          m[n] = m[2*n+1];
          x[n] = x[2*n+1];
        end else begin
          m[n] = m[2*n];
          x[n] = x[2*n];
        end
      end
    end
    beat_max  = m[0];
    beat_lane = x[0];
  end

  assign O_READY = !out_valid_q || I_READY;
  assign accept  = I_VALID && O_READY;
  assign consume = out_valid_q && I_READY;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    acc_max_d   = acc_max_q;
    acc_idx_d   = acc_idx_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_ovf_d   = out_ovf_q;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        StFirst: begin
          acc_max_d  = beat_max;
          acc_idx_d  = IDX_W'(beat_lane);
          beat_cnt_d = CNT_W'(1);
          ovf_d      = 1'b0;
        end
        StAcc: begin
          if (beat_cnt_q < CNT_W'(MAX_BEATS)) begin
            if (beats(beat_max, acc_max_q)) begin
              acc_max_d = beat_max;
              // beat_cnt*LANES + lane; the dropped MSB is zero below MAX_BEATS.
              acc_idx_d = IDX_W'({beat_cnt_q, beat_lane});
            end
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = StFirst;
        end
      endcase

      if (I_LAST) begin
        state_d     = StFirst;
        out_valid_d = 1'b1;
        out_max_d   = acc_max_d;
        out_idx_d   = acc_idx_d;
        out_ovf_d   = ovf_d;
      end else begin
        state_d = StAcc;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= StFirst;
      beat_cnt_q  <= '0;
      acc_max_q   <= '0;
      acc_idx_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_max_q   <= acc_max_d;
      acc_idx_q   <= acc_idx_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign O_VALID = out_valid_q;
  assign O_MAX   = out_max_q;
  assign O_IDX   = out_idx_q;
  assign O_OVF   = out_ovf_q;

  a_hold: assert property (@(posedge I_CLK) disable iff (I_RST)
    O_VALID && !I_READY |=> O_VALID && $stable(O_MAX) && $stable(O_IDX) && $stable(O_OVF));

  a_cnt_range: assert property (@(posedge I_CLK) disable iff (I_RST)
    beat_cnt_q <= CNT_W'(MAX_BEATS));

endmodule

// File: tb/tb_row_max_argmax_stream.sv
// Bench for row_max_argmax_stream: three configurations share one stimulus stream and are
// checked against a linear-scan row model plus directed vectors.
module tb_row_max_argmax_stream;

  typedef logic [0:15][15:0] beat_t;

  typedef struct packed {
    logic [2:0][15:0] m;
    logic [2:0][9:0]  ix;
    logic [2:0]       ov;
  } exp_t;

  typedef struct {
    beat_t       data;
    logic [15:0] s_max;
    logic [9:0]  s_idx;
    logic [15:0] u_max;
    logic [9:0]  u_idx;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  valid;
  logic  last;
  logic  ready;
  beat_t data;

  wire [2:0]        o_ready;
  wire [2:0]        o_valid;
  wire [2:0][15:0]  o_max;
  wire [2:0][9:0]   o_idx;
  wire [2:0]        o_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit rnd_done = 1'b0;

  logic [15:0] row_q[$];
  int          row_beats = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  // Instance 0: signed, 64 beats; 1: unsigned, 64 beats; 2: signed, 4 beats.
  row_max_argmax_stream #(.D_W(16), .LANES(16), .MAX_BEATS(64), .SIGNED(1'b1)) u_dut_s (
    .I_CLK(clk), .I_RST(rst), .I_VALID(valid), .O_READY(o_ready[0]), .I_DATA(data),
    .I_LAST(last), .O_VALID(o_valid[0]), .I_READY(ready), .O_MAX(o_max[0]),
    .O_IDX(o_idx[0]), .O_OVF(o_ovf[0]));

  row_max_argmax_stream #(.D_W(16), .LANES(16), .MAX_BEATS(64), .SIGNED(1'b0)) u_dut_u (
    .I_CLK(clk), .I_RST(rst), .I_VALID(valid), .O_READY(o_ready[1]), .I_DATA(data),
    .I_LAST(last), .O_VALID(o_valid[1]), .I_READY(ready), .O_MAX(o_max[1]),
    .O_IDX(o_idx[1]), .O_OVF(o_ovf[1]));

  row_max_argmax_stream #(.D_W(16), .LANES(16), .MAX_BEATS(4), .SIGNED(1'b1)) u_dut_m4 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(valid), .O_READY(o_ready[2]), .I_DATA(data),
    .I_LAST(last), .O_VALID(o_valid[2]), .I_READY(ready), .O_MAX(o_max[2]),
    .O_IDX(o_idx[2][5:0]), .O_OVF(o_ovf[2]));

  assign o_idx[2][9:6] = '0;

  function automatic int cfg_maxb(input int k);
    return (k == 2) ? 4 : 64;
  endfunction

  function automatic bit cfg_sgn(input int k);
    return k != 1;
  endfunction

  function automatic bit gt(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Row result from the spec rules: first strict maximum over the counted prefix.
  function automatic void ref_row(input int k, output logic [15:0] m, output logic [9:0] ix,
                                  output logic ov);
    int lim;
    lim = (row_beats > cfg_maxb(k)) ? cfg_maxb(k) * 16 : row_beats * 16;
    m   = row_q[0];
    ix  = '0;
    for (int i = 1; i < lim; i++) begin
      if (gt(row_q[i], m, cfg_sgn(k))) begin
        m  = row_q[i];
        ix = 10'(i);
      end
    end
    ov = row_beats > cfg_maxb(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input int k, input logic [15:0] m,
                            input logic [9:0] ix, input logic ov);
    chk($sformatf("%s.valid[%0d]", tag, k), 32'(o_valid[k]), 32'd1);
    chk($sformatf("%s.max[%0d]", tag, k), 32'(o_max[k]), 32'(m));
    chk($sformatf("%s.idx[%0d]", tag, k), 32'(o_idx[k]), 32'(ix));
    chk($sformatf("%s.ovf[%0d]", tag, k), 32'(o_ovf[k]), 32'(ov));
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.valid[%0d]", tag, k), 32'(o_valid[k]), 32'd0);
      chk($sformatf("%s.max[%0d]", tag, k), 32'(o_max[k]), 32'd0);
      chk($sformatf("%s.idx[%0d]", tag, k), 32'(o_idx[k]), 32'd0);
      chk($sformatf("%s.ovf[%0d]", tag, k), 32'(o_ovf[k]), 32'd0);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_beat(input beat_t d, input logic l);
    bit acc;
    int n;
    valid = 1'b1;
    data  = d;
    last  = l;
    n     = 0;
    do begin
      @(negedge clk);
      acc = o_ready[0];
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    chk("accept_wait", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    int mode;
    mode = $urandom_range(0, 2);
    for (int l = 0; l < 16; l++) begin
      case (mode)
        0:       b[l] = 16'($urandom);
        1:       b[l] = 16'($urandom_range(0, 3));
        default: b[l] = 16'($urandom_range(0, 6)) - 16'd3;
      endcase
    end
    return b;
  endfunction

  // Scoreboard sampled mid-cycle: values seen here decide the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_v;
      exp_t e;
      logic [15:0] m;
      logic [9:0]  ix;
      logic        ov;
      exp_v = exp_q.size() != 0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("mon.valid[%0d]", k), 32'(o_valid[k]), 32'(exp_v));
        chk($sformatf("mon.ready[%0d]", k), 32'(o_ready[k]), 32'(!exp_v || ready));
      end
      if (exp_v) begin
        e = exp_q[0];
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("mon.max[%0d]", k), 32'(o_max[k]), 32'(e.m[k]));
          chk($sformatf("mon.idx[%0d]", k), 32'(o_idx[k]), 32'(e.ix[k]));
          chk($sformatf("mon.ovf[%0d]", k), 32'(o_ovf[k]), 32'(e.ov[k]));
        end
        if (ready) void'(exp_q.pop_front());
      end
      if (rst) begin
        row_q.delete();
        row_beats = 0;
        exp_q.delete();
      end else if (valid && (!exp_v || ready)) begin
        for (int l = 0; l < 16; l++) row_q.push_back(data[l]);
        row_beats++;
        if (last) begin
          for (int k = 0; k < 3; k++) begin
            ref_row(k, m, ix, ov);
            e.m[k]  = m;
            e.ix[k] = ix;
            e.ov[k] = ov;
          end
          exp_q.push_back(e);
          row_q.delete();
          row_beats = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs [6];
    beat_t b;

    for (int i = 0; i < 6; i++) vecs[i].data = '0;
    vecs[0].data[0] = 16'hFFFB; vecs[0].data[1] = 16'd3;
    vecs[0].data[2] = 16'd7;    vecs[0].data[3] = 16'hFFFF;
    vecs[0].s_max = 16'd7;      vecs[0].s_idx = 10'd2;
    vecs[0].u_max = 16'hFFFF;   vecs[0].u_idx = 10'd3;
    for (int l = 0; l < 16; l++) vecs[1].data[l] = 16'h7FFF;
    vecs[1].data[9] = 16'h8000;
    vecs[1].s_max = 16'h7FFF;   vecs[1].s_idx = 10'd0;
    vecs[1].u_max = 16'h8000;   vecs[1].u_idx = 10'd9;
    vecs[2].s_max = 16'd0;      vecs[2].s_idx = 10'd0;
    vecs[2].u_max = 16'd0;      vecs[2].u_idx = 10'd0;
    vecs[3].data[15] = 16'd1;
    vecs[3].s_max = 16'd1;      vecs[3].s_idx = 10'd15;
    vecs[3].u_max = 16'd1;      vecs[3].u_idx = 10'd15;
    for (int l = 0; l < 16; l++) vecs[4].data[l] = 16'hFFFF;
    vecs[4].s_max = 16'hFFFF;   vecs[4].s_idx = 10'd0;
    vecs[4].u_max = 16'hFFFF;   vecs[4].u_idx = 10'd0;
    for (int l = 0; l < 16; l++) vecs[5].data[l] = 16'h8000;
    vecs[5].data[8] = 16'h8001;
    vecs[5].s_max = 16'h8001;   vecs[5].s_idx = 10'd8;
    vecs[5].u_max = 16'h8001;   vecs[5].u_idx = 10'd8;

    rst   = 1'b1;
    valid = 1'b0;
    last  = 1'b0;
    ready = 1'b1;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");
    mon_en = 1'b1;

    // Single-beat rows, back to back with the result consumed at once.
    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].data, 1'b1);
      chk_result($sformatf("vec%0d", i), 0, vecs[i].s_max, vecs[i].s_idx, 1'b0);
      chk_result($sformatf("vec%0d", i), 1, vecs[i].u_max, vecs[i].u_idx, 1'b0);
      chk_result($sformatf("vec%0d", i), 2, vecs[i].s_max, vecs[i].s_idx, 1'b0);
    end

    // Three-beat row with a cross-beat tie on 0x7FFF.
    for (int l = 0; l < 16; l++) b[l] = 16'hFF9C;
    send_beat(b, 1'b0);
    b[5] = 16'h7FFF;
    send_beat(b, 1'b0);
    chk("tie.mid_valid", 32'(o_valid[0]), 32'd0);
    b[5] = 16'hFF9C;
    b[0] = 16'h7FFF;
    send_beat(b, 1'b1);
    chk_result("tie", 0, 16'h7FFF, 10'd21, 1'b0);
    chk_result("tie", 1, 16'hFF9C, 10'd0, 1'b0);
    chk_result("tie", 2, 16'h7FFF, 10'd21, 1'b0);
    idle(1);

    // Backpressure for 5 cycles, then release while the next row's last beat waits.
    ready = 1'b0;
    b = '0;
    b[4] = 16'd123;
    send_beat(b, 1'b1);
    chk_result("bp.first", 0, 16'd123, 10'd4, 1'b0);
    b = '0;
    b[1] = 16'd77;
    data = b;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp.ready_c%0d", c), 32'(o_ready[0]), 32'd0);
      chk_result($sformatf("bp.hold_c%0d", c), 0, 16'd123, 10'd4, 1'b0);
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk_result("bp.next", 0, 16'd77, 10'd1, 1'b0);
    chk_result("bp.next", 2, 16'd77, 10'd1, 1'b0);
    idle(1);

    // Six-beat row overflows the 4-beat instance only.
    for (int i = 0; i < 6; i++) begin
      b = '0;
      if (i == 0) b[3] = 16'd10;
      if (i == 5) b[0] = 16'd50;
      send_beat(b, i == 5);
    end
    chk_result("ovf", 0, 16'd50, 10'd80, 1'b0);
    chk_result("ovf", 1, 16'd50, 10'd80, 1'b0);
    chk_result("ovf", 2, 16'd10, 10'd3, 1'b1);
    b = '0;
    b[2] = 16'd5;
    send_beat(b, 1'b1);
    chk_result("ovf.next", 2, 16'd5, 10'd2, 1'b0);

    // Reset in the middle of a row discards the partial result.
    b = '0;
    b[0] = 16'd900;
    send_beat(b, 1'b0);
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("midrst");
    b = '0;
    b[6] = 16'd4;
    send_beat(b, 1'b1);
    for (int k = 0; k < 3; k++) chk_result("midrst.row", k, 16'd4, 10'd6, 1'b0);
    idle(1);

    // Random rows, gaps and backpressure, checked by the scoreboard.
    fork
      begin
        for (int r = 0; r < 60; r++) begin
          int nb;
          nb = $urandom_range(1, 7);
          for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_beat(rand_beat(), i == nb - 1);
          end
        end
        valid    = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready = ($urandom_range(0, 2) != 0);
        end
      end
    join

    ready = 1'b1;
    idle(4);
    chk("drain.pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
